// File: rtl/dct_pkg.sv
// Shared constants for the 8x8 forward DCT peripheral: cosine ROM, register map, FSM states.
package dct_pkg;

  typedef logic signed [9:0] coef_t;

  localparam int         NUM_COEF  = 64;
  localparam logic [6:0] ADDR_CTRL = 7'd64;

  typedef enum logic [1:0] {IDLE, ROW, COL, DONE} state_t;

  // C[u][x] = round(256 * k(u) * cos((2x+1)u*pi/16)), k(0)=sqrt(1/8), k(u>0)=1/2
  localparam coef_t COEF [8][8] = '{
    '{ 10'sd91,   10'sd91,   10'sd91,   10'sd91,   10'sd91,   10'sd91,   10'sd91,   10'sd91  },
    '{ 10'sd126,  10'sd106,  10'sd71,   10'sd25,  -10'sd25,  -10'sd71,  -10'sd106, -10'sd126 },
    '{ 10'sd118,  10'sd49,  -10'sd49,  -10'sd118, -10'sd118, -10'sd49,   10'sd49,   10'sd118 },
    '{ 10'sd106, -10'sd25,  -10'sd126, -10'sd71,   10'sd71,   10'sd126,  10'sd25,  -10'sd106 },
    '{ 10'sd91,  -10'sd91,  -10'sd91,   10'sd91,   10'sd91,  -10'sd91,  -10'sd91,   10'sd91  },
    '{ 10'sd71,  -10'sd126,  10'sd25,   10'sd106, -10'sd106, -10'sd25,   10'sd126, -10'sd71  },
    '{ 10'sd49,  -10'sd118,  10'sd118, -10'sd49,  -10'sd49,   10'sd118, -10'sd118,  10'sd49  },
    '{ 10'sd25,  -10'sd71,   10'sd106, -10'sd126,  10'sd126, -10'sd106,  10'sd71,  -10'sd25  }
  };

endpackage

// File: rtl/dct8_dot.sv
// Combinational 8-point DCT: res[u] = (sum_x vec[x]*C[u][x] + half) >>> COEF_FRAC, 32-bit signed.
module dct8_dot
  import dct_pkg::*;
#(
  parameter int COEF_FRAC = 8
) (
  input  logic [7:0][31:0] vec,
  output logic [7:0][31:0] res
);

  for (genvar u = 0; u < 8; u++) begin : g_out
    logic signed [31:0] acc;

    always_comb begin
      acc = 32'sd1 <<< (COEF_FRAC - 1);
      for (int x = 0; x < 8; x++)
        acc = acc + $signed(vec[x]) * 32'(COEF[u][x]);
    end

    assign res[u] = acc >>> COEF_FRAC;
  end

endmodule

// File: rtl/dct_module.sv
// 8x8 forward 2D DCT as a Wishbone classic slave; one shared 8-point engine runs 8 row then 8 column passes.
module dct_module
  import dct_pkg::*;
#(
  parameter int COEF_FRAC = 8,
  parameter int DW        = 32
) (
  input  logic          CLK_I,
  input  logic          RST_I,
  input  logic [DW-1:0] DAT_I,
  output logic [DW-1:0] DAT_O,
  input  logic [31:0]   ADR_I,
  input  logic          WE_I,
  input  logic          STB_I,
  input  logic          CYC_I,
  input  logic [3:0]    SEL_I,
  output logic          ACK_O
);

  logic [6:0]        addr;
  logic              req;
  logic [DW-1:0]     rdata;
  state_t            state;
  logic [2:0]        cnt;
  logic              busy, done;
  logic signed [15:0] x_buf [NUM_COEF];
  logic signed [31:0] t_buf [NUM_COEF];
  logic signed [31:0] y_buf [NUM_COEF];
  logic [7:0][31:0]  vec, res;
  logic              unused_bits;

  assign addr        = ADR_I[6:0];
  assign req         = STB_I & CYC_I & ~ACK_O;
  assign unused_bits = ^{SEL_I, ADR_I[31:7], DAT_I[DW-1:16]};

  // ROW feeds one input row; COL feeds one column of the intermediate matrix
  always_comb begin
    vec = '0;
    for (int i = 0; i < 8; i++)
      vec[i] = (state == COL) ? t_buf[{3'(i), cnt}] : 32'(x_buf[{cnt, 3'(i)}]);
  end

  dct8_dot #(.COEF_FRAC(COEF_FRAC)) u_dot (
    .vec (vec),
    .res (res)
  );

  always_comb begin
    rdata = '0;
    if (addr < ADDR_CTRL)
      rdata = DW'(y_buf[addr[5:0]]);
    else if (addr == ADDR_CTRL)
      rdata = DW'({done, busy});
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      ACK_O <= 1'b0;
      DAT_O <= '0;
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      for (int i = 0; i < NUM_COEF; i++) begin
        x_buf[6'(i)] <= '0;
        t_buf[6'(i)] <= '0;
        y_buf[6'(i)] <= '0;
      end
    end else begin
      ACK_O <= req;
      if (req && !WE_I)
        DAT_O <= rdata;
      if (req && WE_I && !busy && addr < ADDR_CTRL)
        x_buf[addr[5:0]] <= DAT_I[15:0];

      case (state)
        IDLE: if (req && WE_I && addr == ADDR_CTRL) begin
          state <= ROW;
          cnt   <= '0;
          busy  <= 1'b1;
          done  <= 1'b0;
        end
        ROW: begin
          for (int u = 0; u < 8; u++)
            t_buf[{cnt, 3'(u)}] <= res[u];
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) state <= COL;
        end
        COL: begin
          for (int v = 0; v < 8; v++)
            y_buf[{3'(v), cnt}] <= res[v];
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) state <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dct_module.sv
// Self-checking bench for dct_module: register-map table, reference-model transforms, busy/reset corner cases.
module tb_dct_module;

  logic        clk = 1'b0;
  logic        rst, we, stb, cyc, ack;
  logic [31:0] adr, dat_w, dat_r, rd;
  logic [3:0]  sel;

  int  nvec = 0, nerr = 0;
  int  cm [8][8];
  int  xm [64];
  int  ym [64];
  int  yold [64];
  real kf, rf;

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [10];

  always #5 clk = ~clk;

  dct_module dut (
    .CLK_I (clk),
    .RST_I (rst),
    .DAT_I (dat_w),
    .DAT_O (dat_r),
    .ADR_I (adr),
    .WE_I  (we),
    .STB_I (stb),
    .CYC_I (cyc),
    .SEL_I (sel),
    .ACK_O (ack)
  );

  task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s[%0d]: got %0d, expected %0d", nm, idx, $signed(act), $signed(exp));
    end
  endtask

  task automatic bus_cycle(input logic w, input logic [31:0] a, input logic [31:0] d);
    bit got = 0;
    @(negedge clk);
    adr = a; dat_w = d; we = w; stb = 1'b1; cyc = 1'b1; sel = 4'($urandom);
    for (int i = 0; i < 4 && !got; i++) begin
      @(posedge clk); #1;
      got = ack;
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    if (!got) begin
      nvec++; nerr++;
      $display("FAIL ack_timeout[%0d]: got no acknowledge, expected one", a);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bus_cycle(1'b1, a, d);
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    bus_cycle(1'b0, a, 32'h0);
    d = dat_r;
  endtask

  // Reference: separable 2D DCT straight from the defining sums
  task automatic run_model();
    int t [64];
    int acc;
    for (int r = 0; r < 8; r++)
      for (int u = 0; u < 8; u++) begin
        acc = 128;
        for (int x = 0; x < 8; x++) acc += xm[r*8+x] * cm[u][x];
        t[r*8+u] = acc >>> 8;
      end
    for (int c = 0; c < 8; c++)
      for (int v = 0; v < 8; v++) begin
        acc = 128;
        for (int y = 0; y < 8; y++) acc += t[y*8+c] * cm[v][y];
        ym[v*8+c] = acc >>> 8;
      end
  endtask

  task automatic load_x();
    for (int i = 0; i < 64; i++)
      bus_write(i, {16'($urandom), 16'(xm[i])});
  endtask

  task automatic wait_done(input string nm);
    logic [31:0] s = '0;
    bit ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      bus_read(64, s);
      ok = (s == 32'd2);
    end
    check(nm, 0, s, 32'd2);
  endtask

  task automatic check_all(input string nm);
    logic [31:0] d;
    for (int i = 0; i < 64; i++) begin
      bus_read(i, d);
      check(nm, i, d, ym[i]);
    end
  endtask

  task automatic transform(input string nm);
    load_x();
    run_model();
    bus_write(64, $urandom);
    wait_done({nm, "_status"});
    check_all(nm);
  endtask

  initial begin
    for (int u = 0; u < 8; u++)
      for (int x = 0; x < 8; x++) begin
        kf = (u == 0) ? $sqrt(0.125) : 0.5;
        rf = 256.0 * kf * $cos(real'((2*x+1)*u) * 3.141592653589793 / 16.0);
        cm[u][x] = (rf < 0.0) ? -int'($floor(-rf + 0.5)) : int'($floor(rf + 0.5));
      end

    rst = 1'b1; we = 1'b0; stb = 1'b0; cyc = 1'b0; adr = '0; dat_w = '0; sel = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;

    // reset state: coefficients and status are zero, ack is a single-cycle pulse
    for (int i = 0; i <= 64; i++) begin
      bus_read(i, rd);
      check("reset_read", i, rd, 32'd0);
      @(posedge clk); #1;
      check("ack_pulse", i, {31'b0, ack}, 32'd0);
    end

    // strobe held high: ack on alternate cycles
    @(negedge clk);
    adr = 64; we = 1'b0; stb = 1'b1; cyc = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("ack_alt", i, {31'b0, ack}, 32'((i % 2) == 0));
    end
    stb = 1'b0; cyc = 1'b0;

    for (int i = 0; i < 64; i++) xm[i] = 0;
    transform("zero");

    for (int i = 0; i < 64; i++) xm[i] = 8;
    transform("flat8");

    tbl[0] = '{1'b0, 32'd0,     32'd0,      ym[0]};
    tbl[1] = '{1'b0, 32'd64,    32'd0,      32'd2};
    tbl[2] = '{1'b0, 32'd65,    32'd0,      32'd0};
    tbl[3] = '{1'b0, 32'd127,   32'd0,      32'd0};
    tbl[4] = '{1'b1, 32'd100,   32'h1234,   32'd0};
    tbl[5] = '{1'b0, 32'd100,   32'd0,      32'd0};
    tbl[6] = '{1'b0, 32'd128,   32'd0,      ym[0]};
    tbl[7] = '{1'b0, 32'h1C0,   32'd0,      32'd2};
    tbl[8] = '{1'b1, 32'd5,     32'd999,    32'd2};
    tbl[9] = '{1'b0, 32'd5,     32'd0,      ym[5]};
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].w) bus_write(tbl[i].a, tbl[i].d);
      else          bus_read(tbl[i].a, rd);
      check("reg_map", i, dat_r, tbl[i].exp);
    end

    for (int i = 0; i < 64; i++) xm[i] = i;
    transform("ramp");

    for (int i = 0; i < 64; i++) xm[i] = int'($signed(16'($urandom)));
    transform("rand_a");

    // writes and a second start during the transform are dropped
    yold = ym;
    for (int i = 0; i < 64; i++) xm[i] = int'($signed(16'($urandom)));
    load_x();
    run_model();
    bus_write(64, 0);
    bus_read(63, rd);
    check("busy_old_result", 63, rd, yold[63]);
    bus_write(0, 0);
    bus_write(9, 0);
    bus_write(64, 0);
    bus_read(64, rd);
    check("busy_status", 0, rd, 32'd1);
    wait_done("busy_done");
    check_all("busy_result");

    // rerun on unchanged inputs; done rises exactly 17 cycles after the start ack
    bus_write(64, 0);
    repeat (16) @(posedge clk);
    bus_read(64, rd);
    check("latency_busy", 0, rd, 32'd1);
    wait_done("rerun_done");
    check_all("rerun");
    bus_write(64, 0);
    repeat (17) @(posedge clk);
    bus_read(64, rd);
    check("latency_done", 0, rd, 32'd2);
    check_all("rerun2");

    // reset in the fifth cycle of a transform clears everything
    bus_write(64, 0);
    repeat (4) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    bus_read(64, rd);
    check("mid_rst_status", 0, rd, 32'd0);
    for (int i = 0; i < 64; i++) begin xm[i] = 0; ym[i] = 0; end
    check_all("mid_rst_out");
    for (int i = 0; i < 64; i++) xm[i] = (i / 8) * 8 + (i % 8);
    transform("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
